// File: rtl/bcd_disp_pkg.sv
// Glyphs and scan positions for the BCD result display; constants only, no timing or flow control.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      POS_ONES = 2'd0,
      POS_TENS = 2'd1,
      POS_SIGN = 2'd2
   } pos_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational digit-to-glyph decoder; zero latency, no backpressure.
// Codes 10..15 are not decimal digits and render as "E".
module bcd_to_7seg
   import bcd_disp_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] glyph
);

   always_comb begin
      glyph = SEG_E;
      case (digit)
         4'd0: glyph = SEG_0;
         4'd1: glyph = SEG_1;
         4'd2: glyph = SEG_2;
         4'd3: glyph = SEG_3;
         4'd4: glyph = SEG_4;
         4'd5: glyph = SEG_5;
         4'd6: glyph = SEG_6;
         4'd7: glyph = SEG_7;
         4'd8: glyph = SEG_8;
         4'd9: glyph = SEG_9;
         default: glyph = SEG_E;
      endcase
   end

endmodule

// File: rtl/bcd_result_display.sv
// Captures a BCD add/sub result on load and scans it onto a 3-position seven-segment display.
// Capture 1 cycle, glyph 2 cycles after load; load accepted every cycle, no backpressure.
module bcd_result_display
   import bcd_disp_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int CNT_W    = $clog2(SCAN_DIV)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       mode,
   input  logic [3:0] result,
   input  logic       cout,
   output logic [6:0] seg,
   output logic [2:0] an,
   output logic       err
);

   logic [CNT_W-1:0] cnt;
   pos_t             pos;
   logic             valid;
   logic             neg_q;
   logic             tens_q;
   logic [3:0]       ones_q;

   logic             cap_err;
   logic             cap_neg;
   logic             cap_tens;
   logic [3:0]       cap_ones;

   logic [3:0]       dec_digit;
   logic [6:0]       dec_glyph;
   logic [6:0]       glyph_nxt;
   logic [2:0]       an_nxt;
   logic             cnt_wrap;

   // An illegal result stores a non-decimal ones digit so the decoder renders "E".
   always_comb begin
      cap_err  = (result > 4'd9) || (mode && !cout && (result == 4'd0));
      cap_neg  = 1'b0;
      cap_tens = 1'b0;
      cap_ones = result;
      if (cap_err) begin
         cap_ones = 4'hE;
      end else if (!mode) begin
         cap_tens = cout;
      end else if (!cout) begin
         cap_neg  = 1'b1;
         cap_ones = 4'd10 - result;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid  <= 1'b0;
         err    <= 1'b0;
         neg_q  <= 1'b0;
         tens_q <= 1'b0;
         ones_q <= 4'd0;
      end else if (load) begin
         valid  <= 1'b1;
         err    <= cap_err;
         neg_q  <= cap_neg;
         tens_q <= cap_tens;
         ones_q <= cap_ones;
      end
   end

   assign cnt_wrap = (cnt == CNT_W'(SCAN_DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
         pos <= POS_ONES;
      end else begin
         cnt <= cnt_wrap ? '0 : cnt + CNT_W'(1);
         if (cnt_wrap) begin
            case (pos)
               POS_ONES: pos <= POS_TENS;
               POS_TENS: pos <= POS_SIGN;
               default:  pos <= POS_ONES;
            endcase
         end
      end
   end

   assign dec_digit = (pos == POS_TENS) ? {3'b000, tens_q} : ones_q;

   bcd_to_7seg u_dec (
      .digit (dec_digit),
      .glyph (dec_glyph)
   );

   always_comb begin
      glyph_nxt = SEG_BLANK;
      if (valid) begin
         case (pos)
            POS_ONES: glyph_nxt = dec_glyph;
            POS_TENS: glyph_nxt = tens_q ? dec_glyph : SEG_BLANK;
            POS_SIGN: glyph_nxt = neg_q ? SEG_MINUS : SEG_BLANK;
            default:  glyph_nxt = SEG_BLANK;
         endcase
      end
   end

   always_comb begin
      an_nxt = 3'b111;
      case (pos)
         POS_ONES: an_nxt = 3'b110;
         POS_TENS: an_nxt = 3'b101;
         POS_SIGN: an_nxt = 3'b011;
         default:  an_nxt = 3'b111;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg <= SEG_BLANK;
         an  <= 3'b110;
      end else begin
         seg <= glyph_nxt;
         an  <= an_nxt;
      end
   end

endmodule

// File: tb/tb_bcd_result_display.sv
// Scoreboard bench for bcd_result_display with SCAN_DIV=4: stimulus queues timed expectations,
// a negedge monitor pops and compares them.
module tb_bcd_result_display;

   localparam int SD = 4;

   localparam logic [6:0] G0 = 7'b1000000;
   localparam logic [6:0] G1 = 7'b1111001;
   localparam logic [6:0] G2 = 7'b0100100;
   localparam logic [6:0] G4 = 7'b0011001;
   localparam logic [6:0] G7 = 7'b1111000;
   localparam logic [6:0] G9 = 7'b0010000;
   localparam logic [6:0] GM = 7'b0111111;
   localparam logic [6:0] GE = 7'b0000110;
   localparam logic [6:0] GB = 7'b1111111;

   typedef struct {
      int unsigned cyc;
      logic        chk_seg;
      logic [2:0]  an;
      logic [6:0]  seg;
      logic        err;
      string       nm;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load;
   logic       mode;
   logic [3:0] result;
   logic       cout;
   logic [6:0] seg;
   logic [2:0] an;
   logic       err;

   int unsigned abs_cyc = 0;
   int unsigned rel     = 0;
   int          checks   = 0;
   int          failures = 0;
   exp_t        q[$];

   bcd_result_display #(.SCAN_DIV(SD)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .mode   (mode),
      .result (result),
      .cout   (cout),
      .seg    (seg),
      .an     (an),
      .err    (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) abs_cyc <= abs_cyc + 1;

   function automatic void push(int unsigned c, logic cs, logic [2:0] a, logic [6:0] s, logic e, string nm);
      exp_t x;
      x.cyc = c; x.chk_seg = cs; x.an = a; x.seg = s; x.err = e; x.nm = nm;
      q.push_back(x);
   endfunction

   // Position shown after the e-th edge since reset release (an lags the scan counter by one edge).
   function automatic int pidx_for(int unsigned e);
      return int'(((e - 1) / SD) % 3);
   endfunction

   function automatic logic [2:0] an_for(int p);
      case (p)
         0:       return 3'b110;
         1:       return 3'b101;
         default: return 3'b011;
      endcase
   endfunction

   task automatic run_vec(input logic m, input logic [3:0] r, input logic c,
                          input logic [6:0] g_ones, input logic [6:0] g_tens, input logic [6:0] g_sign,
                          input logic e_err, input string nm);
      int unsigned l;
      int          p;
      logic [6:0]  g;
      @(negedge clk);
      mode = m; result = r; cout = c; load = 1'b1;
      l = abs_cyc + 1;
      push(l, 1'b0, an_for(pidx_for(l - rel)), GB, e_err, {nm, "_err"});
      for (int k = 1; k <= 3 * SD; k++) begin
         p = pidx_for(l + k - rel);
         g = (p == 0) ? g_ones : (p == 1) ? g_tens : g_sign;
         push(l + k, 1'b1, an_for(p), g, e_err, nm);
      end
      @(negedge clk);
      load = 1'b0;
      repeat (3 * SD + 1) @(negedge clk);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].cyc <= abs_cyc) begin
            x = q.pop_front();
            checks++;
            if (x.cyc != abs_cyc) begin
               failures++;
               $display("FAIL %s missed at cyc=%0d (due %0d)", x.nm, abs_cyc, x.cyc);
            end else if (an !== x.an || err !== x.err || (x.chk_seg && seg !== x.seg)) begin
               failures++;
               $display("FAIL %s cyc=%0d got an=%b seg=%b err=%b expected an=%b seg=%b err=%b",
                        x.nm, abs_cyc, an, seg, err, x.an, x.chk_seg ? x.seg : seg, x.err);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; load = 1'b1; mode = 1'b0; result = 4'd9; cout = 1'b1;
      for (int i = 1; i <= 3; i++) push(i, 1'b1, 3'b110, GB, 1'b0, "reset_hold");
      repeat (3) @(negedge clk);
      rst_n = 1'b1; load = 1'b0;
      rel = abs_cyc;
      for (int e = 1; e <= 3 * SD + 1; e++)
         push(rel + e, 1'b1, an_for(pidx_for(e)), GB, 1'b0, "blank_scan");
      repeat (3 * SD + 1) @(negedge clk);

      run_vec(1'b0, 4'd4,  1'b1, G4, G1, GB, 1'b0, "add_carry");
      run_vec(1'b1, 4'd8,  1'b0, G2, GB, GM, 1'b0, "sub_neg");
      run_vec(1'b0, 4'hC,  1'b0, GE, GB, GB, 1'b1, "illegal_c");
      run_vec(1'b1, 4'd0,  1'b1, G0, GB, GB, 1'b0, "sub_pos");
      run_vec(1'b1, 4'd0,  1'b0, GE, GB, GB, 1'b1, "illegal_neg0");
      run_vec(1'b0, 4'd7,  1'b0, G7, GB, GB, 1'b0, "add_nocarry");

      @(negedge clk);
      mode = 1'b0; result = 4'd1; cout = 1'b1; load = 1'b1;
      @(negedge clk);
      mode = 1'b1; result = 4'd5; cout = 1'b0;
      run_vec(1'b1, 4'd9, 1'b0, G1, GB, GM, 1'b0, "held_load");

      // Assert reset while the tens position is lit, part-way through its dwell.
      for (int i = 0; i < 3 * SD; i++) begin
         if (pidx_for(abs_cyc - rel) == 1 && ((abs_cyc - rel - 1) % SD) == 1) break;
         @(negedge clk);
      end
      rst_n = 1'b0; load = 1'b1; mode = 1'b1; result = 4'd3; cout = 1'b0;
      push(abs_cyc + 1, 1'b1, 3'b110, GB, 1'b0, "mid_reset");
      @(negedge clk);
      rst_n = 1'b1; load = 1'b0;
      rel = abs_cyc;
      for (int e = 1; e <= 6; e++)
         push(rel + e, 1'b1, an_for(pidx_for(e)), GB, 1'b0, "post_reset_blank");
      repeat (5) @(negedge clk);
      run_vec(1'b0, 4'd9, 1'b0, G9, GB, GB, 1'b0, "reload_mid_dwell");

      for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain %0d expectations left, required 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_result_display.md
# bcd_result_display

Downstream stage of the single-digit BCD adder/subtractor. It captures the 4-bit BCD result, carry-out and mode on a load strobe, converts them to a sign/tens/ones display value, and drives a 3-position time-multiplexed seven-segment display. It also flags results that cannot come from a legal BCD operation.

## Interface
Parameters:
- SCAN_DIV, default 50000: clock cycles each display position stays lit; legal range ≥ 2.
- CNT_W, default $clog2(SCAN_DIV): width of the scan counter.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset; synchronous, active-low.
- load, input, 1: capture strobe; samples mode/result/cout on the same edge.
- mode, input, 1: 0 = add, 1 = subtract; same meaning as the adder/subtractor Mode.
- result, input, 4: BCD result digit from the adder/subtractor.
- cout, input, 1: final carry out from the adder/subtractor.
- seg, output, 7: {g,f,e,d,c,b,a}, active-low segments.
- an, output, 3: position enables, active-low; bit0 = ones, bit1 = tens, bit2 = sign.
- err, output, 1: the last captured value was illegal.

## Operation
Capture and conversion happen in the same cycle as load=1 and are registered:
- mode=0: tens = cout, ones = result, neg = 0. Legal range 0..18.
- mode=1, cout=1: non-negative. tens = 0, ones = result, neg = 0.
- mode=1, cout=0: negative. ones = 10 − result, tens = 0, neg = 1.
- Error when result > 9, or when mode=1, cout=0 and result = 0. In either case err=1, neg=0, and the display shows "E" on the ones position with tens and sign blank.
- Tens position is blank when tens = 0. Sign position shows "−" (g only) when neg=1, otherwise blank.
- valid flag: cleared by reset, set by the first load. While valid=0, all positions are blank and an still scans.

Scan logic:
- cnt counts 0..SCAN_DIV−1 and wraps to 0.
- On wrap, pos advances ones → tens → sign → ones (0 → 1 → 2 → 0).
- an is one-hot-low on pos. seg is the decoded glyph for pos.

Boundary conditions:
- load during a scan does not reset cnt or pos. The new value appears from the next registered output update.
- load held high for several cycles re-captures every cycle. The last sample wins.
- Reset asserted mid-scan: the next edge returns every register to its reset value, regardless of load.

## Timing
- Reset values: seg = 7'b1111111, an = 3'b110 (pos 0 selected, glyph blank), err = 0, cnt = 0, pos = 0, valid = 0, captured digits = 0.
- Capture latency: load at edge N → err and the captured value are valid after edge N.
- seg/an are registered from the captured value and pos, so a new glyph reaches seg one edge after capture: 2 cycles from the load edge, when pos is unchanged.
- Position dwell is exactly SCAN_DIV cycles. A full frame is 3·SCAN_DIV cycles.
- No back-pressure: load is accepted every cycle.

## Structure
- Package bcd_disp_pkg holds:
  - Glyph constants (active-low): SEG_0 = 7'b1000000, SEG_1 = 7'b1111001, SEG_2 = 7'b0100100, SEG_3 = 7'b0110000, SEG_4 = 7'b0011001, SEG_5 = 7'b0010010, SEG_6 = 7'b0000010, SEG_7 = 7'b1111000, SEG_8 = 7'b0000000, SEG_9 = 7'b0010000, SEG_MINUS = 7'b0111111, SEG_E = 7'b0000110, SEG_BLANK = 7'b1111111.
  - Position enum: POS_ONES, POS_TENS, POS_SIGN.
- Sub-module bcd_to_7seg: combinational 4-bit digit → glyph; 10..15 → SEG_E. Instantiated once, fed by a position mux.

## Test plan
All scenarios use SCAN_DIV=4.
- Reset: hold rst_n=0 for 3 cycles with load=1 → seg=1111111, an=110, err=0. After release, an steps 110 → 101 → 011 → 110 every 4 cycles, and all glyphs stay blank.
- Add carry: load mode=0, result=4, cout=1 (7+7=14) → ones shows SEG_4, tens shows SEG_1, sign blank, err=0. Glyph appears 2 cycles after load.
- Subtract negative: load mode=1, result=8, cout=0 (3−5) → ones shows SEG_2, sign shows SEG_MINUS, tens blank.
- Subtract positive: load mode=1, result=0, cout=1 (5−5) → ones shows SEG_0, tens and sign blank.
- Illegal inputs:
  - load result=4'hC, mode=0 → err=1 one cycle after load; ones shows SEG_E, others blank.
  - A following legal load clears err.
  - load mode=1, result=0, cout=0 → err=1.
- Reset and reload mid-scan:
  - Assert rst_n=0 during the tens position → all outputs are at reset values the next cycle.
  - After release, load mode=0, result=9, cout=0 mid-dwell → cnt and pos continue undisturbed; ones shows SEG_9.
